// File: rtl/reg_pipe_pkg.sv
// Shared helpers for the bubble-collapsing register pipeline.
// Holds the stage-acceptance rule so the stage and the top agree on it.
package reg_pipe_pkg;

   // A stage can take a new word when it is empty or its own word is leaving.
   function automatic logic stage_can_load(input logic valid, input logic advance);
      return !valid || advance;
   endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One pipeline stage: valid bit plus data register, loading only real words.
// The advance input says whether this stage's current word leaves at the next edge.
module reg_pipe_stage
   import reg_pipe_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   input  logic             advance,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   logic             valid_reg;
   logic [WIDTH-1:0] data_reg;
   logic             load;

   assign load  = stage_can_load(valid_reg, advance);
   assign valid = valid_reg;
   assign data  = data_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_reg <= 1'b0;
         data_reg  <= RESET_VAL;
      end else begin
         if (flush) begin
            valid_reg <= 1'b0;
         end else if (load) begin
            valid_reg <= up_valid;
         end
         // Bubbles never overwrite the data register.
         if (!flush && load && up_valid) begin
            data_reg <= up_data;
         end
      end
   end

endmodule

// File: rtl/reg_pipe.sv
// Valid/ready register pipeline of DEPTH stages with bubble collapsing,
// synchronous flush and asynchronous active-low reset.
module reg_pipe
   import reg_pipe_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] adv;
   logic [WIDTH-1:0] d [DEPTH];

   // Advance ripples back from the output: a stage moves on if the next one can load.
   always_comb begin
      adv            = '0;
      adv[DEPTH-1]   = out_ready;
      for (int i = DEPTH - 2; i >= 0; i--) begin
         adv[i] = stage_can_load(v[i+1], adv[i+1]);
      end
   end

   assign in_ready  = reset && !flush && stage_can_load(v[0], adv[0]);
   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];

   always_comb begin
      count = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count = count + CW'(v[i]);
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : stage_gen
      logic             up_valid_w;
      logic [WIDTH-1:0] up_data_w;

      if (gi == 0) begin : head
         assign up_valid_w = in_valid && in_ready;
         assign up_data_w  = in_data;
      end else begin : body
         assign up_valid_w = v[gi-1];
         assign up_data_w  = d[gi-1];
      end

      reg_pipe_stage #(
         .WIDTH    (WIDTH),
         .RESET_VAL(RESET_VAL)
      ) u_stage (
         .clk     (clk),
         .reset   (reset),
         .flush   (flush),
         .up_valid(up_valid_w),
         .up_data (up_data_w),
         .advance (adv[gi]),
         .valid   (v[gi]),
         .data    (d[gi])
      );
   end

endmodule

// File: tb/tb_reg_pipe.sv
// Bench for reg_pipe: directed scenarios plus random traffic, with a queue-based
// reference model checked by a monitor sampling on the falling edge.
module tb_reg_pipe;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam logic [WIDTH-1:0] RVAL = 8'h00;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [2:0]       count;

   int vectors     = 0;
   int miscompares = 0;

   logic [WIDTH-1:0] model_q[$];

   reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RVAL)) dut (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_ready(out_ready),
      .count    (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: the model queue holds every accepted word not yet retired.
   always @(negedge clk) begin
      if (!reset) begin
         model_q.delete();
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_in_ready", 32'(in_ready), 32'd0);
      end else if (flush) begin
         check("flush_in_ready", 32'(in_ready), 32'd0);
         model_q.delete();
      end else begin
         check("mon_count", 32'(count), 32'(model_q.size()));
         check("mon_in_ready", 32'(in_ready),
               32'((model_q.size() < DEPTH) || out_ready));
         if (model_q.size() == 0) check("mon_empty_out_valid", 32'(out_valid), 32'd0);
         if (out_valid && out_ready) begin
            if (model_q.size() == 0) begin
               check("mon_unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
               check("mon_out_data", 32'(out_data), 32'(model_q.pop_front()));
            end
         end
         if (in_valid && in_ready) model_q.push_back(in_data);
      end
   end

   initial begin
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #3;
      check("init_out_valid", 32'(out_valid), 32'd0);
      check("init_out_data", 32'(out_data), 32'(RVAL));
      check("init_count", 32'(count), 32'd0);
      step(); step();
      reset = 1'b1;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Stream: three words, no stall; first shows up after edge k+3.
      out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
      step();
      in_data = 8'h22; step();
      in_data = 8'h33; step();
      in_valid = 1'b0; step();
      check("stream_v0", 32'(out_valid), 32'd1);
      check("stream_d0", 32'(out_data), 32'h11);
      step();
      check("stream_d1", 32'(out_data), 32'h22);
      step();
      check("stream_d2", 32'(out_data), 32'h33);
      step();
      check("stream_empty", 32'(out_valid), 32'd0);

      // Backpressure until full, then a simultaneous push and retire.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
         step();
      end
      in_data = 8'hA4;
      #1;
      check("bp_count", 32'(count), 32'd4);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_data", 32'(out_data), 32'hA0);
      out_ready = 1'b1;
      #1;
      check("fullpass_in_ready", 32'(in_ready), 32'd1);
      step();
      check("fullpass_count", 32'(count), 32'd4);
      check("fullpass_out_data", 32'(out_data), 32'hA1);
      in_valid = 1'b0;
      for (int i = 2; i <= 5; i++) begin
         step();
         if (i <= 4) check("drain_data", 32'(out_data), 32'hA0 + 32'(i));
         else        check("drain_empty", 32'(out_valid), 32'd0);
      end

      // Bubble collapse: a gap between two words closes up behind the stalled head.
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h01; step();
      in_valid = 1'b0; step();
      check("bubble_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_data = 8'h02; step();
      in_valid = 1'b0; step();
      check("bubble_count", 32'(count), 32'd2);
      check("bubble_out_data", 32'(out_data), 32'h01);
      check("bubble_in_ready2", 32'(in_ready), 32'd1);

      // Flush with three words inside; an offered word is refused.
      in_valid = 1'b1; in_data = 8'h03; step();
      check("pre_flush_count", 32'(count), 32'd3);
      in_data = 8'h04; flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      check("flush_count", 32'(count), 32'd0);
      check("flush_out_valid", 32'(out_valid), 32'd0);

      // Refill, then reset mid-cycle: outputs clear with no clock edge.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 8'h50 + 8'(i); step();
      end
      in_valid = 1'b0;
      #1;
      check("pre_rst_count", 32'(count), 32'd3);
      reset = 1'b0;
      #1;
      check("midrst_count", 32'(count), 32'd0);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_data", 32'(out_data), 32'(RVAL));
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      step();
      reset = 1'b1;

      // Random traffic against the queue model.
      for (int n = 0; n < 600; n++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 59) == 0);
         if (flush) out_ready = 1'b0;
         step();
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int n = 0; n < 8; n++) step();
      @(negedge clk);
      #1;
      check("final_model_empty", 32'(model_q.size()), 32'd0);
      check("final_out_valid", 32'(out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
